// File: rtl/reg_file_pkg.sv
// Shared constants, index type and packed-port helper for the multi-port register file.
package reg_file_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);
    localparam int MAX_PORTS     = 8;

    typedef logic [AW_DEFAULT-1:0] reg_idx_t;

    // Extracts the register index of one port from a packed per-port index vector.
    function automatic reg_idx_t idx_slice(input logic [MAX_PORTS*AW_DEFAULT-1:0] vec,
                                           input int unsigned port);
        return vec[port*AW_DEFAULT +: AW_DEFAULT];
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: reserve sets, writeback clears, reserve wins a tie.
// With REG_FILE_BYPASS_EN, busy_rs also drops for a register being written this cycle.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    RegWrite,
    input  logic [NWR*AW-1:0] Rd,
    input  logic              Reserve,
    input  logic [AW-1:0]     Reserve_rd,
    input  logic [NRD*AW-1:0] Rs,
    output logic [NRD-1:0]    busy_rs,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_next;

    // Clears are applied first so a same-edge reserve overrides them.
    always_comb begin
        busy_next = busy_q;
        for (int p = 0; p < NWR; p++) begin
            if (RegWrite[p] && (Rd[p*AW +: AW] != '0)) begin
                busy_next[Rd[p*AW +: AW]] = 1'b0;
            end
        end
        if (Reserve && (Reserve_rd != '0)) begin
            busy_next[Reserve_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    always_comb begin
        busy_rs = '0;
        for (int i = 0; i < NRD; i++) begin
            busy_rs[i] = busy_q[Rs[i*AW +: AW]];
`ifdef REG_FILE_BYPASS_EN
            for (int p = 0; p < NWR; p++) begin
                if (RegWrite[p] && (Rd[p*AW +: AW] == Rs[i*AW +: AW]) && (Rs[i*AW +: AW] != '0)) begin
                    busy_rs[i] = 1'b0;
                end
            end
            if (Reserve && (Reserve_rd == Rs[i*AW +: AW])) begin
                busy_rs[i] = busy_q[Rs[i*AW +: AW]];
            end
`endif
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with busy scoreboard and sticky write-conflict flag.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NWR-1:0]      RegWrite,
    input  logic [NWR*AW-1:0]   Rd,
    input  logic [NWR*XLEN-1:0] Write_data,
    input  logic [NRD*AW-1:0]   Rs,
    output logic [NRD*XLEN-1:0] read_data,
    input  logic                Reserve,
    input  logic [AW-1:0]       Reserve_rd,
    output logic [NRD-1:0]      busy_rs,
    output logic [NREGS-1:0]    busy_vec,
    output logic                err_wr_conflict
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_conflict;

    always_comb begin
        wr_conflict = 1'b0;
        for (int a = 0; a < NWR; a++) begin
            for (int b = a + 1; b < NWR; b++) begin
                if (RegWrite[a] && RegWrite[b] && (Rd[a*AW +: AW] == Rd[b*AW +: AW])
                    && (Rd[a*AW +: AW] != '0)) begin
                    wr_conflict = 1'b1;
                end
            end
        end
    end

    // Later ports are assigned last, so the highest-numbered port wins a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            err_wr_conflict <= 1'b0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (RegWrite[p] && (Rd[p*AW +: AW] != '0)) begin
                    regs[Rd[p*AW +: AW]] <= Write_data[p*XLEN +: XLEN];
                end
            end
            if (wr_conflict) begin
                err_wr_conflict <= 1'b1;
            end
        end
    end

    always_comb begin
        read_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (Rs[i*AW +: AW] != '0) begin
                read_data[i*XLEN +: XLEN] = regs[Rs[i*AW +: AW]];
            end
`ifdef REG_FILE_BYPASS_EN
            for (int p = 0; p < NWR; p++) begin
                if (RegWrite[p] && (Rd[p*AW +: AW] == Rs[i*AW +: AW]) && (Rs[i*AW +: AW] != '0)) begin
                    read_data[i*XLEN +: XLEN] = Write_data[p*XLEN +: XLEN];
                end
            end
`endif
        end
    end

    reg_file_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .Rd         (Rd),
        .Reserve    (Reserve),
        .Reserve_rd (Reserve_rd),
        .Rs         (Rs),
        .busy_rs    (busy_rs),
        .busy_vec   (busy_vec)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp (XLEN=64, NREGS=16, NRD=3, NWR=2); honours REG_FILE_BYPASS_EN.
module tb_reg_file_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 16;
    localparam int NRD   = 3;
    localparam int NWR   = 2;
    localparam int AW    = 4;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RD   = 0;
    localparam int K_BUSY = 1;
    localparam int K_ERR  = 2;
    localparam int K_BRS  = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NWR-1:0]      RegWrite = '0;
    logic [NWR*AW-1:0]   Rd = '0;
    logic [NWR*XLEN-1:0] Write_data = '0;
    logic [NRD*AW-1:0]   Rs = '0;
    logic [NRD*XLEN-1:0] read_data;
    logic                Reserve = 1'b0;
    logic [AW-1:0]       Reserve_rd = '0;
    logic [NRD-1:0]      busy_rs;
    logic [NREGS-1:0]    busy_vec;
    logic                err_wr_conflict;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [63:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    reg_file_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .RegWrite        (RegWrite),
        .Rd              (Rd),
        .Write_data      (Write_data),
        .Rs              (Rs),
        .read_data       (read_data),
        .Reserve         (Reserve),
        .Reserve_rd      (Reserve_rd),
        .busy_rs         (busy_rs),
        .busy_vec        (busy_vec),
        .err_wr_conflict (err_wr_conflict)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are settled at the falling edge, so drain the expectation queue there.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e   = exp_q.pop_front();
            act = '0;
            case (e.kind)
                K_RD:    act = read_data[e.idx*XLEN +: XLEN];
                K_BUSY:  act = 64'(busy_vec);
                K_ERR:   act = 64'(err_wr_conflict);
                default: act = 64'(busy_rs);
            endcase
            checks++;
            if (act !== e.value) begin
                errors++;
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.value);
            end
        end
    end

    task automatic checkOutput(input string name, input int kind, input int idx, input logic [63:0] value);
        exp_t e;
        e.name  = name;
        e.kind  = kind;
        e.idx   = idx;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] we,
                                 input logic [3:0] rd0, input logic [63:0] wd0,
                                 input logic [3:0] rd1, input logic [63:0] wd1,
                                 input logic res, input logic [3:0] res_rd,
                                 input logic [3:0] rs0, input logic [3:0] rs1, input logic [3:0] rs2);
        @(posedge clk);
        #1;
        RegWrite   = we;
        Rd         = {rd1, rd0};
        Write_data = {wd1, wd0};
        Reserve    = res;
        Reserve_rd = res_rd;
        Rs         = {rs2, rs1, rs0};
    endtask

    task automatic readOnly(input logic [3:0] rs0, input logic [3:0] rs1, input logic [3:0] rs2);
        applyStimulus(2'b00, 4'd0, 64'd0, 4'd0, 64'd0, 1'b0, 4'd0, rs0, rs1, rs2);
    endtask

    initial begin
        $display("[TB] start, bypass=%0d", BYP);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        readOnly(4'd0, 4'd0, 4'd0);
        checkOutput("reset_rd0", K_RD, 0, 64'd0);
        checkOutput("reset_busy", K_BUSY, 0, 64'd0);
        checkOutput("reset_err", K_ERR, 0, 64'd0);

        // Write x5 while reading it on two ports.
        applyStimulus(2'b01, 4'd5, 64'h11111111, 4'd0, 64'd0, 1'b0, 4'd0, 4'd5, 4'd5, 4'd0);
        checkOutput("wr_same_cycle_rd0", K_RD, 0, BYP ? 64'h11111111 : 64'd0);
        checkOutput("wr_same_cycle_rd1", K_RD, 1, BYP ? 64'h11111111 : 64'd0);
        readOnly(4'd5, 4'd5, 4'd0);
        checkOutput("wr_next_rd0", K_RD, 0, 64'h11111111);
        checkOutput("wr_next_rd1", K_RD, 1, 64'h11111111);

        // Two ports collide on x10 while x9 is reserved.
        applyStimulus(2'b11, 4'd10, 64'h22222222, 4'd10, 64'h33333333, 1'b1, 4'd9, 4'd10, 4'd5, 4'd0);
        checkOutput("conflict_same_rd0", K_RD, 0, BYP ? 64'h33333333 : 64'd0);
        checkOutput("conflict_err_pre", K_ERR, 0, 64'd0);
        readOnly(4'd10, 4'd5, 4'd9);
        checkOutput("conflict_rd0", K_RD, 0, 64'h33333333);
        checkOutput("conflict_err", K_ERR, 0, 64'd1);
        checkOutput("reserve9_busy", K_BUSY, 0, 64'h200);
        checkOutput("reserve9_busy_rs", K_BRS, 0, 64'b100);
        applyStimulus(2'b01, 4'd11, 64'h55, 4'd0, 64'd0, 1'b0, 4'd0, 4'd10, 4'd0, 4'd0);
        readOnly(4'd11, 4'd10, 4'd0);
        checkOutput("clean_rd0", K_RD, 0, 64'h55);
        checkOutput("clean_rd1", K_RD, 1, 64'h33333333);
        checkOutput("err_sticky", K_ERR, 0, 64'd1);

        // Short asynchronous reset pulse between edges.
        readOnly(4'd5, 4'd10, 4'd9);
        reset = 1'b1;
        #3 reset = 1'b0;
        checkOutput("async_rst_rd0", K_RD, 0, 64'd0);
        checkOutput("async_rst_rd1", K_RD, 1, 64'd0);
        checkOutput("async_rst_busy", K_BUSY, 0, 64'd0);
        checkOutput("async_rst_err", K_ERR, 0, 64'd0);

        // Write and reserve held off by reset across an edge.
        applyStimulus(2'b01, 4'd5, 64'h77, 4'd0, 64'd0, 1'b1, 4'd6, 4'd0, 4'd0, 4'd0);
        reset = 1'b1;
        readOnly(4'd5, 4'd6, 4'd0);
        reset = 1'b0;
        checkOutput("rst_blocks_wr", K_RD, 0, 64'd0);
        checkOutput("rst_blocks_res", K_BUSY, 0, 64'd0);

        // Register 0 ignores writes and reserves.
        applyStimulus(2'b01, 4'd0, 64'hDEADBEEF, 4'd0, 64'd0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        checkOutput("x0_same_rd0", K_RD, 0, 64'd0);
        readOnly(4'd0, 4'd0, 4'd0);
        checkOutput("x0_rd0", K_RD, 0, 64'd0);
        checkOutput("x0_busy", K_BUSY, 0, 64'd0);

        // Scoreboard reserve, clear, and reserve-beats-write.
        applyStimulus(2'b00, 4'd0, 64'd0, 4'd0, 64'd0, 1'b1, 4'd7, 4'd7, 4'd0, 4'd0);
        checkOutput("res7_pre_brs", K_BRS, 0, 64'd0);
        applyStimulus(2'b01, 4'd7, 64'h44, 4'd0, 64'd0, 1'b0, 4'd0, 4'd7, 4'd0, 4'd0);
        checkOutput("res7_busy", K_BUSY, 0, 64'h80);
        checkOutput("res7_brs", K_BRS, 0, BYP ? 64'd0 : 64'b001);
        checkOutput("wr7_same_rd0", K_RD, 0, BYP ? 64'h44 : 64'd0);
        readOnly(4'd7, 4'd0, 4'd0);
        checkOutput("wr7_clear_busy", K_BUSY, 0, 64'd0);
        checkOutput("wr7_clear_brs", K_BRS, 0, 64'd0);
        checkOutput("wr7_rd0", K_RD, 0, 64'h44);
        applyStimulus(2'b10, 4'd0, 64'd0, 4'd7, 64'h66, 1'b1, 4'd7, 4'd7, 4'd0, 4'd0);
        checkOutput("reswr7_same_brs", K_BRS, 0, 64'd0);
        checkOutput("reswr7_same_rd0", K_RD, 0, BYP ? 64'h66 : 64'h44);
        readOnly(4'd7, 4'd0, 4'd0);
        checkOutput("reswr7_busy", K_BUSY, 0, 64'h80);
        checkOutput("reswr7_brs", K_BRS, 0, 64'b001);
        checkOutput("reswr7_rd0", K_RD, 0, 64'h66);
        checkOutput("reswr7_err", K_ERR, 0, 64'd0);

        // Wide data on both write ports, distinct targets.
        applyStimulus(2'b11, 4'd3, 64'h0123456789ABCDEF, 4'd15, 64'hFFFFFFFFFFFFFFFF,
                      1'b0, 4'd0, 4'd3, 4'd15, 4'd0);
        readOnly(4'd3, 4'd15, 4'd0);
        checkOutput("wide_rd0", K_RD, 0, 64'h0123456789ABCDEF);
        checkOutput("wide_rd1", K_RD, 1, 64'hFFFFFFFFFFFFFFFF);
        checkOutput("wide_rd2", K_RD, 2, 64'd0);
        checkOutput("wide_err", K_ERR, 0, 64'd0);
        readOnly(4'd0, 4'd3, 4'd15);
        checkOutput("port_swap_rd0", K_RD, 0, 64'd0);
        checkOutput("port_swap_rd1", K_RD, 1, 64'h0123456789ABCDEF);
        checkOutput("port_swap_rd2", K_RD, 2, 64'hFFFFFFFFFFFFFFFF);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file for the RV32I core family. It generalises the single-write, dual-read register file to N read ports and M write ports, with configurable width and depth. It adds a per-register busy scoreboard so that multi-cycle or pipelined producers can reserve a destination register. It sits between decode (read ports, reserve) and writeback (write ports).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, ≥2)
NRD, 2, number of read ports
NWR, 1, number of write ports (1..4)
AW, $clog2(NREGS), register index width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
RegWrite  in  NWR  per-port write enable
Rd  in  NWR*AW  per-port destination index, port p at bits [p*AW +: AW]
Write_data  in  NWR*XLEN  per-port write data
Rs  in  NRD*AW  per-port source index
read_data  out  NRD*XLEN  per-port read data
Reserve  in  1  mark Reserve_rd busy
Reserve_rd  in  AW  register index to reserve
busy_rs  out  NRD  busy bit of each Rs
busy_vec  out  NREGS  full scoreboard
err_wr_conflict  out  1  sticky flag: two enabled write ports targeted the same nonzero Rd in one cycle

Behaviour:
- Reset (asynchronous, reset=1): all registers = 0, busy_vec = 0, err_wr_conflict = 0.
  - While reset is high, writes and reserves are ignored.
  - Deassertion takes effect at the next rising edge.
- Register 0 is hardwired to zero.
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0.
  - Reserve of index 0 is ignored; busy_vec[0] is always 0.
- Write: on a rising edge, for each port p with RegWrite[p]=1 and Rd[p]≠0, reg[Rd[p]] ← Write_data[p].
  - New value is visible on read_data from the cycle after the edge.
- Same-Rd write collision: the highest-numbered port wins. err_wr_conflict is set at that edge and stays 1 until reset.
- Read: asynchronous/combinational, zero latency.
  - read_data[i] = reg[Rs[i]] when the bypass feature is absent.
- Scoreboard:
  - At an edge with Reserve=1 and Reserve_rd≠0, busy[Reserve_rd] ← 1.
  - At an edge where any enabled write port targets r≠0, busy[r] ← 0.
  - If a reserve and a write hit the same r at the same edge, the reserve wins and busy[r] stays 1 (a new producer has issued).
  - busy_rs[i] = busy_vec[Rs[i]], combinational.
- A write to a register that is not busy is legal and does not affect the scoreboard.
- Out-of-range indices cannot occur (NREGS = 2^AW).

Optional Feature:
REG_FILE_BYPASS_EN
- Defined: write-to-read forwarding.
  - If any enabled write port has Rd = Rs[i] ≠ 0 in the current cycle, read_data[i] = that port's Write_data.
  - The same highest-port-wins priority applies.
  - busy_rs[i] also reads 0 when forwarding from a write in that cycle, unless a Reserve of the same index is also present.
- Undefined: reads return the stored value only. The new value appears the cycle after the write edge.

Decomposition:
- Package reg_file_pkg:
  - XLEN_DEFAULT and NREGS_DEFAULT constants.
  - typedef reg_idx_t (logic [AW-1:0] for the default NREGS).
  - Function idx_slice(vector, port) for packed-port extraction.
- Sub-module reg_file_scoreboard: busy_vec storage, reserve/clear priority, busy_rs lookup.
- Storage, write arbitration and the bypass mux stay in reg_file_mp.

Test Plan:
1. Reset mid-run: write x5=0x11111111, then pulse reset for 3 ns between edges → read x5 = 0, busy_vec = 0, err_wr_conflict = 0 immediately (asynchronous).
2. Write x5=0x11111111 (RegWrite[0]=1), Rs[0]=Rs[1]=5 in the same cycle.
   - Without bypass: 0 that cycle, 0x11111111 the next cycle.
   - With REG_FILE_BYPASS_EN: 0x11111111 in the same cycle.
3. Write x0=0xDEADBEEF and Reserve x0 → read x0 = 0, busy_vec[0] = 0 at the next cycle.
4. NWR=2: port0 x10=0x22222222 and port1 x10=0x33333333 at the same edge → x10 = 0x33333333, err_wr_conflict = 1 and it stays 1 after further clean writes.
5. Scoreboard:
   - Reserve x7 → busy_rs = 1 next cycle.
   - Write x7=0x44 → busy clears the next cycle.
   - Reserve x7 plus write x7 at the same edge → busy stays 1 and x7 = the written data.
6. NRD=3, XLEN=64, NREGS=16: write x3=0x0123456789ABCDEF, x15=all-ones, then Rs=(3,15,0) → (0x0123456789ABCDEF, 0xFFFFFFFFFFFFFFFF, 0).
